// File: rtl/ftw_loader_pkg.sv
// ftw_loader_pkg: shared state encoding, frame geometry and command values
// for the serial tuning-word loader.
package ftw_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    PEND  = 2'd3
  } state_e;

  localparam int FRAME_BITS = 32;
  localparam int FTW_W      = 28;

  localparam logic [3:0] CMD_LOAD_VAL = 4'h1;
  localparam logic [3:0] CMD_NOP_VAL  = 4'h0;

  // Bit counter values: a full frame, and the saturation point that marks
  // "too many bits" without the counter ever wrapping back to a legal count.
  localparam logic [5:0] CNT_FULL = 6'd32;
  localparam logic [5:0] CNT_SAT  = 6'd33;

endpackage

// File: rtl/ftw_loader_sync_edge.sv
// sync_edge: two-flop synchronizer followed by an edge-detect flop.
// With BYPASS set the synchronizer is skipped and only the edge detector
// remains, for inputs that are already in the clock domain.
module sync_edge #(
  parameter bit   BYPASS    = 1'b0,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic data_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  generate
    if (BYPASS) begin : gBypass
      assign level_o = data_i;
    end else begin : gSync
      logic meta_q;
      logic sync_q;

      // Two flops to settle a possibly metastable asynchronous input.
      always_ff @(posedge clock) begin
        if (reset) begin
          meta_q <= RESET_VAL;
          sync_q <= RESET_VAL;
        end else begin
          meta_q <= data_i;
          sync_q <= meta_q;
        end
      end

      assign level_o = sync_q;
    end
  endgenerate

  // Previous level, so rise/fall are one-cycle pulses on a level change.
  always_ff @(posedge clock) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= level_o;
  end

  assign rise_o = level_o & ~prev_q;
  assign fall_o = ~level_o & prev_q;

endmodule

// File: rtl/ftw_loader.sv
// ftw_loader: receives 32-bit command frames over a three-wire serial port
// and drives the phase accumulator's 28-bit tuning word atomically.
// Optional feature macro: FTW_SYNC_UPDATE_EN holds a load in PEND until the
// accumulator wraps (phase_msb falling), keeping the waveform phase-continuous.
module ftw_loader
  import ftw_loader_pkg::*;
#(
  parameter logic [FTW_W-1:0] RESET_FTW = 28'h0000100,
  parameter logic [3:0]       CMD_LOAD  = CMD_LOAD_VAL,
  parameter logic [3:0]       CMD_NOP   = CMD_NOP_VAL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             sdi,
  input  logic             phase_msb,
  output logic [FTW_W-1:0] nco_set,
  output logic             ftw_update,
  output logic             frame_err,
  output logic             busy
);

  state_e                  state_q;
  logic [5:0]              bitCount_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    sdiMeta_q;
  logic                    sdiSync_q;
  logic                    sclkRise;
  logic                    csRise;
  logic                    csFall;
  logic                    unusedSclkLevel;
  logic                    unusedSclkFall;
  logic                    unusedCsLevel;
  logic [3:0]              frameCmd;
  logic [FTW_W-1:0]        frameFtw;
  state_e                  restState;

  sync_edge #(.BYPASS(1'b0), .RESET_VAL(1'b0)) uSclkSync (
    .clock  (clock),
    .reset  (reset),
    .data_i (sclk),
    .level_o(unusedSclkLevel),
    .rise_o (sclkRise),
    .fall_o (unusedSclkFall)
  );

  sync_edge #(.BYPASS(1'b0), .RESET_VAL(1'b1)) uCsSync (
    .clock  (clock),
    .reset  (reset),
    .data_i (cs_n),
    .level_o(unusedCsLevel),
    .rise_o (csRise),
    .fall_o (csFall)
  );

  // sdi gets the same two-flop delay as sclk so the bit lines up with its edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sdiMeta_q <= 1'b0;
      sdiSync_q <= 1'b0;
    end else begin
      sdiMeta_q <= sdi;
      sdiSync_q <= sdiMeta_q;
    end
  end

  assign frameCmd = shift_q[FRAME_BITS-1 -: 4];
  assign frameFtw = shift_q[FTW_W-1:0];
  assign busy     = (state_q != IDLE);

`ifdef FTW_SYNC_UPDATE_EN
  logic [FTW_W-1:0] shadow_q;
  logic             pending_q;
  logic             wrap;
  logic             unusedPhaseLevel;
  logic             unusedPhaseRise;

  sync_edge #(.BYPASS(1'b1), .RESET_VAL(1'b0)) uPhaseEdge (
    .clock  (clock),
    .reset  (reset),
    .data_i (phase_msb),
    .level_o(unusedPhaseLevel),
    .rise_o (unusedPhaseRise),
    .fall_o (wrap)
  );

  // A frame that ends without a new load falls back to PEND if a load waits.
  assign restState = pending_q ? PEND : IDLE;
`else
  logic unusedPhaseMsb;
  assign unusedPhaseMsb = phase_msb;
  assign restState      = IDLE;
`endif

  // Frame FSM: shift bits in, validate the frame, then apply or defer the load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCount_q <= '0;
      shift_q    <= '0;
      nco_set    <= RESET_FTW;
      ftw_update <= 1'b0;
      frame_err  <= 1'b0;
`ifdef FTW_SYNC_UPDATE_EN
      shadow_q   <= RESET_FTW;
      pending_q  <= 1'b0;
`endif
    end else begin
      ftw_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_q    <= SHIFT;
            bitCount_q <= '0;
            shift_q    <= '0;
          end
        end
        SHIFT: begin
          if (sclkRise) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], sdiSync_q};
            if (bitCount_q != CNT_SAT) bitCount_q <= bitCount_q + 6'd1;
          end
          if (csRise) state_q <= CHECK;
        end
        CHECK: begin
          if (bitCount_q != CNT_FULL) begin
            frame_err <= 1'b1;
            state_q   <= restState;
          end else if (frameCmd == CMD_NOP) begin
            state_q <= restState;
          end else if (frameCmd == CMD_LOAD) begin
`ifdef FTW_SYNC_UPDATE_EN
            shadow_q  <= frameFtw;
            pending_q <= 1'b1;
            state_q   <= PEND;
`else
            nco_set    <= frameFtw;
            ftw_update <= 1'b1;
            state_q    <= IDLE;
`endif
          end else begin
            frame_err <= 1'b1;
            state_q   <= restState;
          end
        end
        PEND: begin
`ifdef FTW_SYNC_UPDATE_EN
          if (wrap) begin
            nco_set    <= shadow_q;
            ftw_update <= 1'b1;
            pending_q  <= 1'b0;
            state_q    <= IDLE;
          end
          if (csFall) begin
            state_q    <= SHIFT;
            bitCount_q <= '0;
            shift_q    <= '0;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftw_loader.sv
// tb_ftw_loader: randomized scoreboard bench for ftw_loader.
// Honours FTW_SYNC_UPDATE_EN when the bench is built with it defined.
module tb_ftw_loader;

  localparam logic [27:0] RESET_FTW = 28'h0000100;

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk;
  logic        cs_n;
  logic        sdi;
  logic        phase_msb;
  logic [27:0] nco_set;
  logic        ftw_update;
  logic        frame_err;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lastCsRise = 0;
  int          lastWrap = 0;

  // Scoreboard: expected tuning words in order, and count of expected errors.
  logic [27:0] expQ[$];
  int          expErr = 0;

  // Reference model of the deferred load.
  logic [27:0] mShadow;
  bit          mPending;
  logic [27:0] prevNco;
  logic [27:0] lastLoaded;

  ftw_loader dut (
    .clock     (clock),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .phase_msb (phase_msb),
    .nco_set   (nco_set),
    .ftw_update(ftw_update),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic shiftBit(input logic b);
    sdi = b;
    waitCycles(4);
    sclk = 1'b1;
    waitCycles(4);
    sclk = 1'b0;
  endtask

  // Frame rules: exactly 32 bits, command nibble decides load / nop / reject.
  task automatic modelFrame(input logic [63:0] data, input int nbits);
    logic [3:0] cmd;
    cmd = data[31:28];
    if (nbits != 32) expErr++;
    else if (cmd == 4'h0) begin
    end else if (cmd == 4'h1) begin
`ifdef FTW_SYNC_UPDATE_EN
      mShadow  = data[27:0];
      mPending = 1'b1;
`else
      expQ.push_back(data[27:0]);
`endif
      lastLoaded = data[27:0];
    end else expErr++;
  endtask

  task automatic applyStimulus(input logic [63:0] data, input int nbits);
    cs_n = 1'b0;
    waitCycles(5);
    checkOutput("busy_mid", {31'd0, busy}, 32'd1);
    for (int i = nbits - 1; i >= 0; i--) shiftBit(data[i]);
    waitCycles(4);
    modelFrame(data, nbits);
    cs_n = 1'b1;
    lastCsRise = cycle;
    waitCycles(12);
    checkOutput("busy_after", {31'd0, busy}, {31'd0, mPending});
    checkOutput("upd_drain", expQ.size(), 32'd0);
    checkOutput("err_drain", expErr, 32'd0);
  endtask

  task automatic wrapPulse();
    phase_msb = 1'b1;
    waitCycles(3);
    if (mPending) begin
      expQ.push_back(mShadow);
      mPending = 1'b0;
    end
    phase_msb = 1'b0;
    lastWrap  = cycle;
    waitCycles(4);
    checkOutput("wrap_drain", expQ.size(), 32'd0);
    checkOutput("busy_wrap", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every output pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset) prevNco = nco_set;
    else begin
      if (ftw_update && frame_err) begin
        checks++;
        errors++;
        $display("[TB] FAIL pulse_overlap actual=11 required=not both");
      end
      if (ftw_update) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_update actual=%h required=no pulse", nco_set);
        end else checkOutput("nco_value", {4'd0, nco_set}, {4'd0, expQ.pop_front()});
`ifdef FTW_SYNC_UPDATE_EN
        checkOutput("wrap_latency", cycle - lastWrap, 32'd1);
`else
        checkOutput("load_latency", cycle - lastCsRise, 32'd4);
`endif
      end else if (nco_set !== prevNco) begin
        checks++;
        errors++;
        $display("[TB] FAIL nco_without_update actual=%h required=%h", nco_set, prevNco);
      end
      if (frame_err) begin
        checks++;
        if (expErr == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_frame_err actual=1 required=0");
        end else expErr--;
      end
      prevNco = nco_set;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] data;
    int          kind;
    int          nbits;

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0; phase_msb = 1'b0;
    mPending = 1'b0; mShadow = RESET_FTW; lastLoaded = RESET_FTW;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(4);
    checkOutput("reset_nco", {4'd0, nco_set}, {4'd0, RESET_FTW});
    checkOutput("reset_upd", {31'd0, ftw_update}, 32'd0);
    checkOutput("reset_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    // Wrong lengths are rejected and leave the word alone.
    applyStimulus(64'h0000_0000_1000_0200 >> 1, 31);
    applyStimulus(64'h0000_0001_1000_0200, 33);
    checkOutput("len_nco", {4'd0, nco_set}, {4'd0, RESET_FTW});

    applyStimulus(64'h1A7C5AC4, 32);
`ifdef FTW_SYNC_UPDATE_EN
    wrapPulse();
`endif
    checkOutput("load_nco", {4'd0, nco_set}, 32'h0A7C5AC4);

    applyStimulus(64'h0FFFFFFF, 32);
    applyStimulus(64'h30000001, 32);
    checkOutput("nop_bad_nco", {4'd0, nco_set}, 32'h0A7C5AC4);

`ifdef FTW_SYNC_UPDATE_EN
    phase_msb = 1'b1;
    applyStimulus(64'h10044B83, 32);
    checkOutput("pend_busy", {31'd0, busy}, 32'd1);
    checkOutput("pend_nco", {4'd0, nco_set}, 32'h0A7C5AC4);
    wrapPulse();
    checkOutput("wrap_nco", {4'd0, nco_set}, 32'h00044B83);

    applyStimulus(64'h10000200, 32);
    applyStimulus(64'h10000300, 32);
    applyStimulus(64'h50000777, 32);
    wrapPulse();
    checkOutput("last_wins", {4'd0, nco_set}, 32'h00000300);
`endif

    for (int n = 0; n < 10; n++) begin
      kind  = $urandom_range(0, 4);
      nbits = 32;
      data  = {32'd0, $urandom()};
      case (kind)
        0, 1: data[31:28] = 4'h1;
        2:    data[31:28] = 4'h0;
        3:    data[31:28] = 4'($urandom_range(2, 15));
        default: begin
          nbits = ($urandom_range(0, 1) != 0) ? $urandom_range(20, 31) : $urandom_range(33, 36);
          data  = {$urandom(), $urandom()};
        end
      endcase
      applyStimulus(data, nbits);
`ifdef FTW_SYNC_UPDATE_EN
      if ($urandom_range(0, 1) != 0) wrapPulse();
`endif
    end
`ifdef FTW_SYNC_UPDATE_EN
    wrapPulse();
`endif
    checkOutput("random_nco", {4'd0, nco_set}, {4'd0, lastLoaded});

    // Leave a load pending (deferred build), then reset mid-frame.
    applyStimulus(64'h10000ABC, 32);
    cs_n = 1'b0;
    waitCycles(5);
    for (int i = 0; i < 16; i++) shiftBit(1'($urandom_range(0, 1)));
    reset = 1'b1;
    mPending = 1'b0;
    expQ.delete();
    expErr = 0;
    waitCycles(2);
    cs_n = 1'b1;
    sdi  = 1'b0;
    waitCycles(1);
    reset = 1'b0;
    waitCycles(6);
    checkOutput("midreset_nco", {4'd0, nco_set}, {4'd0, RESET_FTW});
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);

    applyStimulus(64'h11234567, 32);
`ifdef FTW_SYNC_UPDATE_EN
    wrapPulse();
`endif
    checkOutput("post_reset_nco", {4'd0, nco_set}, 32'h01234567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
